// File: rtl/sap3_pkg.sv
// ============================================================================
// Module : sap3_pkg
// Brief  : Shared ALU op codes, flag bit indices and sequencer state encodings
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package sap3_pkg;

  // ALU operation codes, shared with the ALU datapath
  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_ADC = 5'b00001;
  localparam logic [4:0] ALU_SUB = 5'b00010;
  localparam logic [4:0] ALU_SBB = 5'b00011;
  localparam logic [4:0] ALU_ANA = 5'b00100;
  localparam logic [4:0] ALU_XRA = 5'b00101;
  localparam logic [4:0] ALU_ORA = 5'b00110;
  localparam logic [4:0] ALU_CMP = 5'b00111;
  localparam logic [4:0] ALU_RLC = 5'b01000;
  localparam logic [4:0] ALU_RRC = 5'b01001;
  localparam logic [4:0] ALU_RAL = 5'b01010;
  localparam logic [4:0] ALU_RAR = 5'b01011;
  localparam logic [4:0] ALU_CMA = 5'b01101;
  localparam logic [4:0] ALU_STC = 5'b01110;
  localparam logic [4:0] ALU_CMC = 5'b01111;
  localparam logic [4:0] ALU_INR = 5'b10000;
  localparam logic [4:0] ALU_DCR = 5'b10001;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_P = 2;
  localparam int FLAG_S = 3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_EXEC  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // ooo field of 00ooo111 that is DAA, which this sequencer does not support
  localparam logic [2:0] OOO_DAA = 3'b100;

endpackage

`default_nettype wire

// File: rtl/alu_seq_decode.sv
// ============================================================================
// Module : alu_seq_decode
// Brief  : Combinational 8080-style opcode decode for the ALU sequencer
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_seq_decode
  import sap3_pkg::*;
#(
  parameter logic [2:0] MEM_SRC = 3'b110
) (
  input  logic [7:0] opcode,
  output logic [4:0] alu_op,
  output logic       two_op,
  output logic       use_mem,
  output logic       illegal
);

  always_comb begin
    alu_op  = 5'b00000;
    two_op  = 1'b0;
    use_mem = 1'b0;
    illegal = 1'b1;
    if (opcode[7:6] == 2'b10) begin
      alu_op  = {2'b00, opcode[5:3]};
      two_op  = 1'b1;
      use_mem = (opcode[2:0] == MEM_SRC);
      illegal = 1'b0;
    end else if (opcode[7:6] == 2'b11 && opcode[2:0] == 3'b110) begin
      // immediate operand arrives through the memory path
      alu_op  = {2'b00, opcode[5:3]};
      two_op  = 1'b1;
      use_mem = 1'b1;
      illegal = 1'b0;
    end else if (opcode[7:6] == 2'b00 && opcode[2:0] == 3'b111 &&
                 opcode[5:3] != OOO_DAA) begin
      alu_op  = {2'b01, opcode[5:3]};
      illegal = 1'b0;
    end else if (opcode == 8'h3C) begin
      alu_op  = ALU_INR;
      illegal = 1'b0;
    end else if (opcode == 8'h3D) begin
      alu_op  = ALU_DCR;
      illegal = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_seq.sv
// ============================================================================
// Module : alu_seq
// Brief  : ALU instruction sequencer (IDLE -> FETCH -> EXEC -> DONE)
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_seq
  import sap3_pkg::*;
#(
  parameter logic [2:0] MEM_SRC = 3'b110
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] opcode,
  input  logic [7:0] flags,
  output logic       alu_cs,
  output logic       alu_tmp_we,
  output logic [4:0] alu_op,
  output logic       src_oe,
  output logic       mem_oe,
  output logic [2:0] src_sel,
  output logic       done,
  output logic       illegal,
  output logic [7:0] flags_q
);

  logic [1:0] r_state;
  logic [1:0] w_next_state;
  logic [7:0] r_opcode;
  logic [7:0] w_dec_in;
  logic [4:0] w_dec_alu_op;
  logic       w_dec_two_op;
  logic       w_dec_use_mem;
  logic       w_dec_illegal;
  logic       w_accept;
  logic       w_reg_src;

  // IDLE decodes the live opcode to choose the next state; later states
  // decode the latched copy so outputs stay stable for the whole instruction
  assign w_dec_in  = (r_state == ST_IDLE) ? opcode : r_opcode;
  assign w_accept  = in_valid && (r_state == ST_IDLE);
  assign w_reg_src = w_dec_two_op && !w_dec_use_mem;

  alu_seq_decode #(
    .MEM_SRC (MEM_SRC)
  ) u_decode (
    .opcode  (w_dec_in),
    .alu_op  (w_dec_alu_op),
    .two_op  (w_dec_two_op),
    .use_mem (w_dec_use_mem),
    .illegal (w_dec_illegal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_opcode <= 8'h00;
    end else if (w_accept) begin
      r_opcode <= opcode;
    end
  end

  // ALU settles flags on the falling edge inside EXEC
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= 8'h00;
    end else if (r_state == ST_EXEC) begin
      flags_q <= flags;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          if (w_dec_illegal) begin
            w_next_state = ST_DONE;
          end else if (w_dec_two_op) begin
            w_next_state = ST_FETCH;
          end else begin
            w_next_state = ST_EXEC;
          end
        end
      end
      ST_FETCH: w_next_state = ST_EXEC;
      ST_EXEC:  w_next_state = ST_DONE;
      ST_DONE:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready   = 1'b0;
    alu_tmp_we = 1'b0;
    alu_cs     = 1'b0;
    src_oe     = 1'b0;
    mem_oe     = 1'b0;
    done       = 1'b0;
    illegal    = 1'b0;
    alu_op     = 5'b00000;
    src_sel    = 3'b000;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
      end
      ST_FETCH: begin
        alu_tmp_we = 1'b1;
        alu_op     = w_dec_alu_op;
        src_oe     = w_reg_src;
        mem_oe     = w_dec_use_mem;
        src_sel    = w_reg_src ? r_opcode[2:0] : 3'b000;
      end
      ST_EXEC: begin
        alu_cs  = 1'b1;
        alu_op  = w_dec_alu_op;
        src_sel = w_reg_src ? r_opcode[2:0] : 3'b000;
      end
      ST_DONE: begin
        done    = 1'b1;
        illegal = w_dec_illegal;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter MEM_SRC, default 3'b110: the sss field value that selects a memory operand instead of a register.
REQ-002 SHALL have port clk  input  1  single system clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  opcode offered by fetch stage.
REQ-005 SHALL have port in_ready  output  1  sequencer can accept an opcode.
REQ-006 SHALL have port opcode  input  8  8080-style opcode, sampled when in_valid && in_ready.
REQ-007 SHALL have port flags  input  8  ALU flag register (Z=bit0, C=1, P=2, S=3).
REQ-008 SHALL have ports alu_cs, alu_tmp_we  output  1 each  ALU execute strobe, ALU temp-register load.
REQ-009 SHALL have port alu_op  output  5  ALU operation code.
REQ-010 SHALL have ports src_oe, mem_oe  output  1 each  register-file / memory operand drive onto bus.
REQ-011 SHALL have port src_sel  output  3  register-file read select (opcode sss).
REQ-012 SHALL have ports done, illegal  output  1 each  completion pulse; unsupported-opcode indication valid with done.
REQ-013 SHALL have port flags_q  output  8  flag snapshot for the completed instruction.

Function
REQ-014 SHALL implement states IDLE, FETCH, EXEC, DONE; in_ready=1 only in IDLE.
REQ-015 SHALL, in IDLE with in_valid=1, latch opcode and go to FETCH for two-operand ops, EXEC for single-operand ops, DONE (illegal=1) for unsupported ops.
REQ-016 SHALL decode two-operand register group 10ooosss -> alu_op={2'b00,ooo}; sss!=MEM_SRC drives src_oe=1, src_sel=sss; sss==MEM_SRC drives mem_oe=1.
REQ-017 SHALL decode immediate group 11ooo110 -> alu_op={2'b00,ooo}, operand via mem_oe=1.
REQ-018 SHALL decode 00ooo111 -> alu_op={2'b01,ooo}, single-operand; ooo=100 (0x27, DAA) is illegal.
REQ-019 SHALL decode 0x3C -> alu_op=5'b10000, 0x3D -> 5'b10001, single-operand; every other opcode is illegal.
REQ-020 SHALL, in FETCH (exactly one cycle), assert alu_tmp_we=1 with the selected operand enable, then go to EXEC.
REQ-021 SHALL, in EXEC (exactly one cycle), assert alu_cs=1 with alu_op held stable, then go to DONE.
REQ-022 SHALL capture flags into flags_q on the rising edge leaving EXEC (ALU updates flags on the falling edge inside EXEC).
REQ-023 SHALL, in DONE (exactly one cycle), assert done=1, then return to IDLE; flags_q is held until the next EXEC exit.
REQ-024 SHALL, for an illegal opcode, assert no ALU/operand strobes, leave flags_q unchanged, and assert illegal=1 with done.
REQ-025 SHALL give latency accept->done of 3 cycles (two-operand), 2 (single-operand), 1 (illegal).
REQ-026 SHALL ignore in_valid while not in IDLE; a held opcode is accepted on the first IDLE cycle.
REQ-027 SHALL drive alu_tmp_we, alu_cs, src_oe, mem_oe, done and illegal as mutually exclusive with their state; never two operand enables at once.
REQ-028 SHALL drive alu_op and src_sel to 0 outside FETCH/EXEC.

Reset
REQ-029 SHALL, on rst=1 at any time, immediately force IDLE, all strobes 0, alu_op=0, src_sel=0, flags_q=0, latched opcode=0.
REQ-030 SHALL, on reset during FETCH/EXEC, abort the instruction with no done pulse.

Structure
REQ-031 SHALL place ALU op codes (5-bit, shared with the ALU), flag bit indices and state encodings in shared package sap3_pkg.
REQ-032 SHALL isolate opcode decode in one combinational sub-module alu_seq_decode (opcode -> alu_op, two_op, use_mem, illegal).

Verification
REQ-033 SHALL check 0x80 (ADD B): FETCH src_oe=1, src_sel=000, alu_tmp_we=1; EXEC alu_cs=1, alu_op=00000; done 3 cycles after accept.
REQ-034 SHALL check 0xBE (CMP M) with ALU flags returning 0x01: mem_oe=1 in FETCH, alu_op=00111, flags_q=0x01 at done.
REQ-035 SHALL check 0x17 (RAL): no FETCH, alu_cs=1 with alu_op=01010, done 2 cycles after accept.
REQ-036 SHALL check 0x27 and 0x76: done=1, illegal=1 one cycle after accept, zero alu_cs/alu_tmp_we, flags_q unchanged.
REQ-037 SHALL check rst pulsed mid-EXEC of 0xC6 (ADI): outputs 0 asynchronously, no done, next 0x3C then completes normally.
REQ-038 SHALL check back-to-back in_valid with 0x80 then 0x3D: second accepted only when in_ready returns, both complete in order.
